regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter and sequencer for the single write port of the dual-read register file. It accepts write requests from NREQ producers (ALU, load unit, CSR/debug) over valid/ready handshakes. It grants one producer per cycle by round-robin and drives a registered write (we/waddr/wdata) into the register file. It also reports the in-flight write so the issue logic can detect read-after-write hazards against the register file's two read ports.

Parameters:
NREQ, 3, number of write requesters (2..8)
DATA_W, 32, register data width
ADDR_W, 5, register address width (2^ADDR_W entries)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
hold  input  1  when 1, no grants are issued this cycle
req_valid  input  NREQ  per-requester write request
req_addr  input  NREQ*ADDR_W  packed destination addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NREQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NREQ  one-hot-or-zero grant; transfer when valid&ready
rf_we  output  1  register-file write enable
rf_waddr  output  ADDR_W  register-file write address
rf_wdata  output  DATA_W  register-file write data
last_gnt  output  $clog2(NREQ)  index of the most recently granted requester
chk_addr_a  input  ADDR_W  read address A to check for a hazard
chk_addr_b  input  ADDR_W  read address B to check for a hazard
hzd_a  output  1  rf_we & (rf_waddr == chk_addr_a)
hzd_b  output  1  rf_we & (rf_waddr == chk_addr_b)

Behaviour:
- Reset (rst=1, async): rf_we=0, rf_waddr=0, rf_wdata=0, last_gnt=NREQ-1, rr pointer=NREQ-1. req_ready is forced to 0 while rst is high. hzd_a and hzd_b read 0.
- Arbitration is combinational from the current req_valid and the rr pointer. Search order is ptr+1, ptr+2, … modulo NREQ. The first valid requester gets req_ready=1; all others get 0.
- req_ready is never asserted to a requester whose req_valid is 0. At most one bit of req_ready is set.
- hold=1: req_ready=0 for all requesters; the rr pointer is unchanged.
- Grant in cycle t:
  - At the edge ending t, the output register loads rf_we=1 and the granted requester's addr/data.
  - The rr pointer and last_gnt load the granted index.
  - Latency from handshake to rf_we is 1 cycle.
- No grant in cycle t: rf_we=0 in t+1. rf_waddr and rf_wdata hold their previous values.
- The register file always accepts writes, so the output stage never back-pressures. Sustained throughput is 1 write per cycle.
- Fairness: a continuously valid requester is granted within NREQ cycles of its first valid cycle, provided hold=0.
- Requesters must hold addr/data stable while valid and not ready. The arbiter does not latch non-granted requests.
- Simultaneous writes to the same address by different requesters are serialized in round-robin order. The later grant wins in the register file.
- hzd_a and hzd_b are combinational from the output register and chk_addr_*. They flag a write that lands at the next edge, so a same-cycle asynchronous read returns stale data.
- Reset asserted mid-stream: any registered write is discarded (rf_we=0 immediately). No partial state survives.

Optional Feature:
REGWB_ZERO_REG_EN
- Defined: register 0 is hardwired to zero. A granted request with addr==0 still completes its handshake (req_ready=1) and advances the rr pointer, but the next cycle shows rf_we=0. hzd_a and hzd_b are never asserted for address 0.
- Undefined: address 0 is an ordinary register; writes to it are issued normally.

Decomposition:
- Package regfile_pkg: DATA_W/ADDR_W defaults, a rf_wr_t struct {we, addr, data}, and a function rr_next(ptr, NREQ).
- Sub-module rr_arbiter (NREQ req bits, ptr in → one-hot gnt plus encoded index). It is reusable for the later read-port arbiter.
- Output register, hazard compare and zero-register logic live in the top module.

Test Plan:
- Reset, then req_valid=3'b111 held with hold=0 → grants in order 0,1,2,0…; rf_we=1 every cycle from cycle 2, with rf_waddr following each requester's address.
- Single requester 1 valid: addr=5, data=0xDEADBEEF → req_ready=3'b010 in the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- hold=1 for 3 cycles with all valid → req_ready=0 and rf_we=0 throughout; after hold drops, the first grant goes to (last_gnt+1) mod 3.
- Requesters 0 and 2 both valid with addr=7, data 0x11 then 0x22 → two consecutive writes; hzd_a=1 in both write cycles for chk_addr_a=7; the final value written is the one granted second.
- rst pulsed asynchronously mid-cycle while rf_we=1 → rf_we, rf_waddr and rf_wdata drop to 0 before the next edge; after release, requester 0 is granted first.
- With REGWB_ZERO_REG_EN, request addr=0 → handshake completes, the next cycle shows rf_we=0 and hzd_a=0 for chk_addr_a=0. Without the macro → rf_we=1, rf_waddr=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-back path.
//   REG_DATA_W / REG_ADDR_W : default data and address widths
//   rf_wr_t                 : one register-file write {we, addr, data}
//   rr_next()               : round-robin successor of a pointer modulo nreq
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } rf_wr_t;

    // Next index after ptr, wrapping at nreq (nreq need not be a power of two).
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
        int unsigned nxt;
        if (ptr + 32'd1 >= nreq) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches ptr+1, ptr+2, ... modulo NREQ
// and grants the first requester found.
// Ports:
//   req_i  [NREQ-1:0]  request vector
//   ptr_i  [IDX_W-1:0] index granted most recently (search starts after it)
//   gnt_o  [NREQ-1:0]  one-hot-or-zero grant
//   idx_o  [IDX_W-1:0] encoded index of the grant (0 when none)
//   any_o              a grant was made
// ---------------------------------------------------------------------------
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand_s;

    // Walk the candidates in rotating order; the first active one wins.
    always_comb begin
        gnt_o  = {NREQ{1'b0}};
        idx_o  = {IDX_W{1'b0}};
        any_o  = 1'b0;
        cand_s = ptr_i;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDX_W'(rr_next(32'(cand_s), 32'(NREQ)));
            if (!any_o && req_i[cand_s]) begin
                any_o         = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
            end else begin
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-back arbiter for the single write port of the register file.
// Grants one of NREQ producers per cycle (round-robin), registers the winning
// write towards the register file and flags read-after-write hazards for the
// two read ports.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   hold_i                  suppress all grants this cycle
//   req_valid_i/addr_i/data_i  packed producer requests (i at [i*W +: W])
//   req_ready_o             one-hot-or-zero grant (combinational)
//   rf_we_o/waddr_o/wdata_o registered register-file write
//   last_gnt_o              most recently granted index
//   chk_addr_a_i/b_i        read addresses to check
//   hzd_a_o/hzd_b_o         pending write targets the checked address
// Build option: REGWB_ZERO_REG_EN makes register 0 hardwired zero (writes to
// it complete their handshake but are not issued; no hazards on address 0).
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hold_i,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*DATA_W-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic                     rf_we_o,
    output logic [ADDR_W-1:0]        rf_waddr_o,
    output logic [DATA_W-1:0]        rf_wdata_o,
    output logic [$clog2(NREQ)-1:0]  last_gnt_o,
    input  logic [ADDR_W-1:0]        chk_addr_a_i,
    input  logic [ADDR_W-1:0]        chk_addr_b_i,
    output logic                     hzd_a_o,
    output logic                     hzd_b_o
);

    localparam int IDX_W = $clog2(NREQ);

`ifdef REGWB_ZERO_REG_EN
    localparam logic ZERO_REG_EN = 1'b1;
`else
    localparam logic ZERO_REG_EN = 1'b0;
`endif

    logic [NREQ-1:0]   gnt_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              gnt_any_s;
    logic              fire_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    logic              we_q,    we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s),
        .idx_o (gnt_idx_s),
        .any_o (gnt_any_s)
    );

    // Qualify the raw arbiter grant with hold and reset.
    always_comb begin
        if (hold_i || rst_i) begin
            req_ready_o = {NREQ{1'b0}};
            fire_s      = 1'b0;
        end else begin
            req_ready_o = gnt_s;
            fire_s      = gnt_any_s;
        end
    end

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        sel_addr_s = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s = sel_addr_s | ({ADDR_W{gnt_s[i]}} & req_addr_i[i*ADDR_W +: ADDR_W]);
            sel_data_s = sel_data_s | ({DATA_W{gnt_s[i]}} & req_data_i[i*DATA_W +: DATA_W]);
        end
    end

    // A write to the hardwired zero register is accepted but never issued.
    assign wr_en_s = ~(ZERO_REG_EN & (sel_addr_s == {ADDR_W{1'b0}}));

    // Next state: load on grant; otherwise drop we and keep addr/data/pointer.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        if (fire_s) begin
            we_d    = wr_en_s;
            waddr_d = sel_addr_s;
            wdata_d = sel_data_s;
            ptr_d   = gnt_idx_s;
        end else begin
            we_d    = 1'b0;
        end
    end

    // Output write register and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            waddr_q <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            ptr_q   <= IDX_W'(NREQ - 1);
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rf_we_o    = we_q;
    assign rf_waddr_o = waddr_q;
    assign rf_wdata_o = wdata_q;
    assign last_gnt_o = ptr_q;

    // Hazard: the registered write lands at the next edge on a checked address.
    always_comb begin
        hzd_a_o = we_q & (waddr_q == chk_addr_a_i)
                & ~(ZERO_REG_EN & (waddr_q == {ADDR_W{1'b0}}));
        hzd_b_o = we_q & (waddr_q == chk_addr_b_i)
                & ~(ZERO_REG_EN & (waddr_q == {ADDR_W{1'b0}}));
    end

endmodule
